// File: rtl/instr_prefetch_queue_if.sv
// Handshake bundle between the prefetch queue, instruction memory and the core.
// The master modport is the prefetch queue's view; slave is the environment's.
interface instr_prefetch_queue_if;
    logic        flush;
    logic [63:0] flush_pc;
    logic        mem_req;
    logic [63:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [63:0] instr_pc;
    logic        instr_ready;

    modport master (
        input  flush, flush_pc, mem_ack, mem_rdata, instr_ready,
        output mem_req, mem_addr, instr_valid, instr, instr_pc
    );

    modport slave (
        output flush, flush_pc, mem_ack, mem_rdata, instr_ready,
        input  mem_req, mem_addr, instr_valid, instr, instr_pc
    );
endinterface

// File: rtl/instr_prefetch_queue.sv
// Instruction prefetch queue: single-outstanding memory fetch feeding a
// first-word-fall-through FIFO of {pc, word}, with flush/redirect support.
module instr_prefetch_queue #(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    instr_prefetch_queue_if.master       bus,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DRAIN
    } state_t;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] word;
    } entry_t;

    state_t        state, state_next;
    logic [63:0]   fpc;
    logic [63:0]   fpc_inc;
    logic [63:0]   flush_fpc;
    logic [63:0]   mem_addr_q;
    logic [63:0]   addr_next;
    entry_t        fifo [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count_next;
    logic          push, pop, has_room, valid;

    assign fpc_inc   = fpc + 64'd4;
    assign flush_fpc = {bus.flush_pc[63:2], 2'b00};
    assign valid     = (count != '0);
    assign pop       = valid && bus.instr_ready && !bus.flush;
    assign push      = (state == WAIT) && bus.mem_ack && !bus.flush;

    // Occupancy after this cycle's push/pop; issue is gated on it so that a
    // returning word always has a reserved slot.
    always_comb begin
        count_next = count;
        if (bus.flush)
            count_next = '0;
        else if (push && !pop)
            count_next = count + CW'(1);
        else if (!push && pop)
            count_next = count - CW'(1);
    end

    assign has_room = (count_next < CW'(DEPTH));

    // NOTE: every output of this block gets a default first so no path
    // through the case leaves a variable unassigned, which would infer a latch.
    always_comb begin
        state_next = state;
        addr_next  = mem_addr_q;
        case (state)
            IDLE: begin
                if (!bus.flush && has_room) begin
                    state_next = WAIT;
                    addr_next  = fpc;
                end
            end
            WAIT: begin
                if (bus.flush)
                    state_next = bus.mem_ack ? IDLE : DRAIN;
                else if (bus.mem_ack) begin
                    if (has_room)
                        addr_next = fpc_inc;
                    else
                        state_next = IDLE;
                end
            end
            DRAIN: begin
                if (bus.mem_ack)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: registers use non-blocking assignment so every flop samples the
    // pre-edge value of its inputs regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fpc        <= '0;
            mem_addr_q <= '0;
            count      <= '0;
        end else begin
            mem_addr_q <= addr_next;
            count      <= count_next;
            if (bus.flush)
                fpc <= flush_fpc;
            else if (push)
                fpc <= fpc_inc;
        end
    end

    // NOTE: the storage array is reset because the head entry is driven
    // straight to instr/instr_pc, which must read zero out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++)
                fifo[i] <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else if (bus.flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (push) begin
                fifo[wr_ptr] <= '{pc: mem_addr_q, word: bus.mem_rdata};
                wr_ptr       <= wr_ptr + AW'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
        end
    end

    assign bus.mem_req     = (state != IDLE);
    assign bus.mem_addr    = mem_addr_q;
    assign bus.instr_valid = valid;
    assign bus.instr       = fifo[rd_ptr].word;
    assign bus.instr_pc    = fifo[rd_ptr].pc;

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Bench for instr_prefetch_queue: queue-based reference model compared every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_instr_prefetch_queue;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int LAT   = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [CW-1:0] count;

    instr_prefetch_queue_if bus ();

    instr_prefetch_queue #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .count (count)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory contents: a recognisable function of the word address.
    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    // Memory responder. mode 0: manual values; 1: zero-wait; 2: ack after LAT idle cycles.
    int          mode = 0;
    logic        man_ack = 1'b0;
    logic [31:0] man_rdata = '0;

    initial begin
        int wait_cnt;
        wait_cnt      = 0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(posedge clk);
            #2;
            if (mode == 1) begin
                bus.mem_ack   = 1'b1;
                bus.mem_rdata = mem_word(bus.mem_addr);
            end else if (mode == 2) begin
                bus.mem_rdata = mem_word(bus.mem_addr);
                if (bus.mem_req && wait_cnt == LAT) begin
                    bus.mem_ack = 1'b1;
                    wait_cnt    = 0;
                end else begin
                    bus.mem_ack = 1'b0;
                    wait_cnt    = bus.mem_req ? wait_cnt + 1 : 0;
                end
            end else begin
                bus.mem_ack   = man_ack;
                bus.mem_rdata = man_rdata;
                wait_cnt      = 0;
            end
        end
    end

    // Reference model: a queue of fetched words plus "one request outstanding,
    // possibly stale" bookkeeping.
    logic [63:0] q_pc [$];
    logic [31:0] q_word [$];
    logic [63:0] m_fpc      = '0;
    logic [63:0] m_req_addr = '0;
    bit          m_busy     = 1'b0;
    bit          m_stale    = 1'b0;
    bit          m_pop, m_issue;

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                q_pc.delete();
                q_word.delete();
                m_fpc      = '0;
                m_req_addr = '0;
                m_busy     = 1'b0;
                m_stale    = 1'b0;
            end else begin
                m_pop   = (q_pc.size() != 0) && bus.instr_ready && !bus.flush;
                m_issue = 1'b0;
                if (bus.flush) begin
                    q_pc.delete();
                    q_word.delete();
                    m_fpc = {bus.flush_pc[63:2], 2'b00};
                    if (m_busy) begin
                        if (bus.mem_ack) begin
                            m_busy  = 1'b0;
                            m_stale = 1'b0;
                        end else
                            m_stale = 1'b1;
                    end
                end else begin
                    if (m_pop) begin
                        void'(q_pc.pop_front());
                        void'(q_word.pop_front());
                    end
                    if (!m_busy)
                        m_issue = (q_pc.size() < DEPTH);
                    else if (bus.mem_ack) begin
                        m_busy = 1'b0;
                        if (m_stale)
                            m_stale = 1'b0;
                        else begin
                            q_pc.push_back(m_req_addr);
                            q_word.push_back(bus.mem_rdata);
                            m_fpc   = m_fpc + 64'd4;
                            m_issue = (q_pc.size() < DEPTH);
                        end
                    end
                    if (m_issue) begin
                        m_busy     = 1'b1;
                        m_req_addr = m_fpc;
                    end
                end
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            check("mem_req", 64'(bus.mem_req), 64'(m_busy));
            if (m_busy)
                check("mem_addr", bus.mem_addr, m_req_addr);
            check("instr_valid", 64'(bus.instr_valid), 64'(q_pc.size() != 0));
            check("count", 64'(count), 64'(q_pc.size()));
            if (q_pc.size() != 0) begin
                check("instr", 64'(bus.instr), 64'(q_word[0]));
                check("instr_pc", bus.instr_pc, q_pc[0]);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".mem_req"},     64'(bus.mem_req), 64'd0);
        check({tag, ".mem_addr"},    bus.mem_addr, 64'd0);
        check({tag, ".instr_valid"}, 64'(bus.instr_valid), 64'd0);
        check({tag, ".instr"},       64'(bus.instr), 64'd0);
        check({tag, ".instr_pc"},    bus.instr_pc, 64'd0);
        check({tag, ".count"},       64'(count), 64'd0);
    endtask

    initial begin
        rst_n           = 1'b0;
        bus.flush       = 1'b0;
        bus.flush_pc    = '0;
        bus.instr_ready = 1'b0;

        #3;
        check_reset_outputs("reset");

        // Fill with zero-wait memory and no consumer.
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        mode  = 1;
        cyc(1);
        check("first_req", 64'(bus.mem_req), 64'd1);
        check("first_addr", bus.mem_addr, 64'h0);
        cyc(1);
        check("fill.count1", 64'(count), 64'd1);
        check("fill.addr4", bus.mem_addr, 64'h4);
        cyc(6);
        check("full.count", 64'(count), 64'd4);
        check("full.mem_req", 64'(bus.mem_req), 64'd0);
        check("full.head_pc", bus.instr_pc, 64'h0);
        check("full.head_word", 64'(bus.instr), 64'h0000_FFFF);

        // Streaming: one instruction per cycle.
        bus.instr_ready = 1'b1;
        cyc(10);
        check("stream.count", 64'(count), 64'd3);
        check("stream.head_pc", bus.instr_pc, 64'h28);

        // Slow memory while consuming, then refill without consumer.
        mode = 2;
        cyc(30);
        bus.instr_ready = 1'b0;
        cyc(40);
        check("slow.count", 64'(count), 64'd4);
        check("slow.mem_req", 64'(bus.mem_req), 64'd0);

        // Flush while waiting with no ack; stale ack arrives two cycles later.
        mode            = 0;
        man_ack         = 1'b0;
        bus.instr_ready = 1'b1;
        cyc(1);
        bus.instr_ready = 1'b0;
        bus.flush       = 1'b1;
        bus.flush_pc    = 64'h1003;
        cyc(1);
        bus.flush = 1'b0;
        check("drain.valid", 64'(bus.instr_valid), 64'd0);
        check("drain.count", 64'(count), 64'd0);
        check("drain.mem_req", 64'(bus.mem_req), 64'd1);
        cyc(1);
        man_ack   = 1'b1;
        man_rdata = 32'hDEAD_BEEF;
        cyc(1);
        man_ack = 1'b0;
        check("drain.done_req", 64'(bus.mem_req), 64'd0);
        check("drain.dropped", 64'(count), 64'd0);
        cyc(1);
        check("redir.mem_req", 64'(bus.mem_req), 64'd1);
        check("redir.mem_addr", bus.mem_addr, 64'h1000);
        mode = 1;
        cyc(6);
        check("redir.head_pc", bus.instr_pc, 64'h1000);
        check("redir.head_word", 64'(bus.instr), 64'h1000_EFFF);

        // Flush coinciding with ack and ready at count=2.
        mode            = 0;
        man_ack         = 1'b0;
        bus.instr_ready = 1'b1;
        cyc(2);
        check("pre_flush.count", 64'(count), 64'd2);
        bus.flush    = 1'b1;
        bus.flush_pc = 64'h2000;
        man_ack      = 1'b1;
        man_rdata    = 32'h1234_5678;
        cyc(1);
        bus.flush       = 1'b0;
        man_ack         = 1'b0;
        bus.instr_ready = 1'b0;
        check("fl_ack.count", 64'(count), 64'd0);
        check("fl_ack.valid", 64'(bus.instr_valid), 64'd0);
        check("fl_ack.idle", 64'(bus.mem_req), 64'd0);
        cyc(1);
        check("fl_ack.req", 64'(bus.mem_req), 64'd1);
        check("fl_ack.addr", bus.mem_addr, 64'h2000);

        // Asynchronous reset with three entries queued and a request outstanding.
        mode = 1;
        cyc(3);
        check("pre_rst.count", 64'(count), 64'd3);
        check("pre_rst.req", 64'(bus.mem_req), 64'd1);
        mode    = 0;
        man_ack = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        mode  = 1;
        cyc(1);
        check("restart.req", 64'(bus.mem_req), 64'd1);
        check("restart.addr", bus.mem_addr, 64'h0);
        cyc(1);
        check("restart.count", 64'(count), 64'd1);
        check("restart.head_pc", bus.instr_pc, 64'h0);
        cyc(6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_prefetch_queue.md
# instr_prefetch_queue

Instruction prefetch stage sitting directly upstream of the multicycle RISC-V processing unit's instruction register. It fetches 32-bit instruction words from instruction memory through a single-outstanding req/ack handshake, queues them with their PCs in a small FIFO, and presents them to the core through a valid/ready interface. A flush from the core redirects fetch to a new PC and discards all queued and in-flight words.

## Interface
- DEPTH, 4, FIFO entries; power of two, 2..16
- clk  in  1  system clock, rising edge
- Reset  in  1  asynchronous, active-low reset
- flush  in  1  redirect request from core (branch/jump taken)
- flush_pc  in  64  new fetch PC; bits [1:0] ignored, treated as 0
- mem_req  out  1  instruction memory read request
- mem_addr  out  64  word address of request; bits [1:0] always 0
- mem_ack  in  1  memory returns data this cycle
- mem_rdata  in  32  instruction word, valid when mem_ack=1
- instr_valid  out  1  head entry available
- instr  out  32  head instruction word
- instr_pc  out  64  PC of head instruction
- instr_ready  in  1  core consumes head this cycle
- count  out  $clog2(DEPTH+1)  number of queued entries

## Operation
- Fetch PC register fpc; FIFO of DEPTH entries of {pc[63:0], word[31:0]}; first-word-fall-through: instr/instr_pc always show head, instr_valid = (count != 0).
- Pop: instr_valid & instr_ready & !flush.
- State machine, three states:
  - IDLE: mem_req=0. If count_next < DEPTH (space after this cycle's pop) and !flush → WAIT, mem_addr latched = fpc.
  - WAIT: mem_req=1, mem_addr held stable. On mem_ack & !flush: push {mem_addr, mem_rdata}, fpc += 4; if space remains after push/pop stay WAIT with mem_addr = fpc+4, else → IDLE. On flush (with or without ack): FIFO cleared, fpc = {flush_pc[63:2],2'b00}; if mem_ack same cycle → IDLE (data discarded), else → DRAIN.
  - DRAIN: mem_req=1, mem_addr held at stale address (handshake never abandoned). On mem_ack: data discarded, → IDLE. Further flush in DRAIN updates fpc, stays DRAIN.
- Flush in IDLE: FIFO cleared, fpc updated, stays IDLE for that cycle.
- Flush has priority over pop and push in the same cycle.
- fpc addition wraps modulo 2^64.
- At most one request outstanding; a push never occurs when full (space reserved at issue).
- Simultaneous push and pop: count unchanged; works also at count=DEPTH-1 and count=1.

## Timing
- Reset (Reset=0, async): state IDLE, fpc=0, FIFO empty, count=0, mem_req=0, mem_addr=0, instr_valid=0, instr=0, instr_pc=0. All outputs registered or decoded from registers only; no combinational path from mem_ack/instr_ready to mem_req.
- First mem_req asserted in the 2nd cycle after Reset release (IDLE → WAIT).
- mem_ack in cycle N → entry visible (instr_valid=1 if queue was empty) in cycle N+1.
- Zero-wait memory (mem_ack tied 1): sustains one word per cycle while space remains.
- flush in cycle N → instr_valid=0 in cycle N+1; first post-flush request issued cycle N+2 (from IDLE) or 1 cycle after stale ack (from DRAIN).
- Reset asserted mid-transaction: all state cleared immediately; memory must tolerate the abandoned request.

## Test plan
- Reset release, mem_ack=1 always, instr_ready=0 → requests at 0x0,0x4,0x8,0xC; count reaches 4, mem_req=0 afterward, instr_pc=0x0 at head.
- Same, instr_ready=1 → steady one instruction per cycle, instr_pc increments by 4, count stable, no gaps after fill.
- mem_ack delayed 3 cycles per request → mem_addr stable while mem_req=1, each word appears cycle after its ack.
- flush_pc=0x1003 while WAIT without ack, ack arrives 2 cycles later with 0xDEADBEEF → DRAIN, word discarded, next mem_addr=0x1000, first instr_pc=0x1000.
- flush same cycle as mem_ack and instr_ready with count=2 → count=0 next cycle, no pop counted, ack data dropped, state IDLE.
- Reset=0 asserted with count=3 and request outstanding → all outputs return to reset values asynchronously; fetch restarts at 0x0.
